hvsync_generator: RTL and testbench
===================================

HVSYNC_GENERATOR -- requirements
Module: hvsync_generator

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_SYNC_START, 720, first CounterX value with horizontal sync asserted.
REQ-003 Parameter H_SYNC_END, 736, first CounterX value after horizontal sync.
REQ-004 Parameter H_TOTAL, 768, pixel clocks per line.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_SYNC_START, 500, first CounterY value with vertical sync asserted.
REQ-007 Parameter V_SYNC_END, 502, first CounterY value after vertical sync.
REQ-008 Parameter V_TOTAL, 512, lines per frame.
REQ-009 clk  input  1  sole clock; all state updates on its rising edge.
REQ-010 rst  input  1  reset, synchronous, active-high.
REQ-011 vga_h_sync  output  1  horizontal sync, active-low.
REQ-012 vga_v_sync  output  1  vertical sync, active-low.
REQ-013 inDisplayArea  output  1  high while the current position is visible.
REQ-014 CounterX  output  10  current pixel column, 0..H_TOTAL-1.
REQ-015 CounterY  output  9  current line, 0..V_TOTAL-1.

Function
REQ-016 Each pixel tick SHALL increment CounterX; at CounterX==H_TOTAL-1 it SHALL wrap to 0 on the same tick.
REQ-017 CounterY SHALL increment only on the tick where CounterX wraps; at CounterY==V_TOTAL-1 with CounterX wrapping, both SHALL go to 0.
REQ-018 A pixel tick SHALL occur on every clk edge with rst low (subject to REQ-027).
REQ-019 vga_h_sync SHALL be 0 exactly when H_SYNC_START <= CounterX < H_SYNC_END, else 1.
REQ-020 vga_v_sync SHALL be 0 exactly when V_SYNC_START <= CounterY < V_SYNC_END, else 1.
REQ-021 inDisplayArea SHALL be 1 exactly when CounterX < H_ACTIVE and CounterY < V_ACTIVE.
REQ-022 All outputs SHALL be registers, computed from next-counter values so that in any cycle the sync and display outputs match that cycle's CounterX/CounterY (zero relative latency, glitch-free).
REQ-023 Comparisons SHALL be unsigned at 10-bit (X) and 9-bit (Y) width; parameters out of range are not supported.

Reset
REQ-024 While rst is high on a clk edge: CounterX=0, CounterY=0, vga_h_sync=1, vga_v_sync=1, inDisplayArea=1 (decode of position 0,0).
REQ-025 First edge with rst low SHALL produce CounterX=1, CounterY=0.
REQ-026 rst asserted mid-frame SHALL return to the reset values on the next edge, with no partial-line state retained.

Configuration
REQ-027 Macro HVSYNC_CLKDIV2_EN defined: an internal toggle flop, reset to 0, SHALL allow a pixel tick only on edges where it is 1, so counters advance every second clk (50 MHz clk -> 25 MHz pixel rate); outputs hold between ticks. Undefined: one tick per clk, no toggle flop.

Structure
REQ-028 Package hvsync_pkg SHALL hold the default timing constants (the REQ-001..008 defaults) and counter widths (10, 9).
REQ-029 Sub-module hvsync_counter, a parameterised width/modulus wrap counter with enable and carry-out, SHALL be instantiated once for X and once for Y (Y enabled by the X carry).

Verification
REQ-030 rst high 3 cycles then low -> during reset X=0, Y=0, syncs=1, inDisplayArea=1; first post-reset edge X=1.
REQ-031 Run 768 ticks from reset -> X wraps 767->0 with Y 0->1; inDisplayArea falls at X=640 and rises at X=0.
REQ-032 Line 0 -> vga_h_sync low for X=720..735 only (16 ticks), high at X=719 and X=736.
REQ-033 Full frame (768*512 ticks) -> vga_v_sync low for Y=500..501, inDisplayArea 0 for Y>=480; X=767, Y=511 wraps to X=0, Y=0.
REQ-034 rst pulsed at X=300, Y=200 -> next edge X=0, Y=0, then normal counting.
REQ-035 HVSYNC_CLKDIV2_EN defined -> 10 clks after reset give X=5; a line takes 1536 clks.

Source files
------------

// File: rtl/hvsync_pkg.sv
// Default VGA-style timing constants and counter widths shared by the sync generator.
// Widths fix the unsigned compare size for the X (column) and Y (line) decoders.
package hvsync_pkg;
  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam int H_ACTIVE_DEF     = 640;
  localparam int H_SYNC_START_DEF = 720;
  localparam int H_SYNC_END_DEF   = 736;
  localparam int H_TOTAL_DEF      = 768;

  localparam int V_ACTIVE_DEF     = 480;
  localparam int V_SYNC_START_DEF = 500;
  localparam int V_SYNC_END_DEF   = 502;
  localparam int V_TOTAL_DEF      = 512;
endpackage

// File: rtl/hvsync_counter.sv
// Modulo-MODULUS wrap counter with enable; carry is high on the enabled tick that wraps.
// count_nxt exposes the value the counter takes on the next edge (reset excluded).
module hvsync_counter #(
  parameter int WIDTH   = 10,
  parameter int MODULUS = 768
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_nxt,
  output logic             carry
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  always_comb begin
    carry     = en && (count == LAST);
    count_nxt = count;
    if (carry)
      count_nxt = '0;
    else if (en)
      count_nxt = count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else
      count <= count_nxt;
  end
endmodule

// File: rtl/hvsync_generator.sv
// Horizontal/vertical sync and display-area generator; outputs decoded from next-counter values.
// Define HVSYNC_CLKDIV2_EN to advance the pixel position only on every second clk.
module hvsync_generator
  import hvsync_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int H_SYNC_START = H_SYNC_START_DEF,
  parameter int H_SYNC_END   = H_SYNC_END_DEF,
  parameter int H_TOTAL      = H_TOTAL_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int V_SYNC_START = V_SYNC_START_DEF,
  parameter int V_SYNC_END   = V_SYNC_END_DEF,
  parameter int V_TOTAL      = V_TOTAL_DEF
) (
  input  logic           clk,
  input  logic           rst,
  output logic           vga_h_sync,
  output logic           vga_v_sync,
  output logic           inDisplayArea,
  output logic [X_W-1:0] CounterX,
  output logic [Y_W-1:0] CounterY
);
  localparam logic [X_W-1:0] HA  = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HSS = X_W'(H_SYNC_START);
  localparam logic [X_W-1:0] HSE = X_W'(H_SYNC_END);
  localparam logic [Y_W-1:0] VA  = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VSS = Y_W'(V_SYNC_START);
  localparam logic [Y_W-1:0] VSE = Y_W'(V_SYNC_END);

  logic           tick;
  logic           x_wrap;
  logic           frame_wrap_unused;
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;

`ifdef HVSYNC_CLKDIV2_EN
  logic pix_phase;

  always_ff @(posedge clk) begin
    if (rst)
      pix_phase <= 1'b0;
    else
      pix_phase <= ~pix_phase;
  end

  assign tick = pix_phase;
`else
  assign tick = 1'b1;
`endif

  hvsync_counter #(.WIDTH(X_W), .MODULUS(H_TOTAL)) u_x_cnt (
    .clk       (clk),
    .rst       (rst),
    .en        (tick),
    .count     (CounterX),
    .count_nxt (x_nxt),
    .carry     (x_wrap)
  );

  hvsync_counter #(.WIDTH(Y_W), .MODULUS(V_TOTAL)) u_y_cnt (
    .clk       (clk),
    .rst       (rst),
    .en        (x_wrap),
    .count     (CounterY),
    .count_nxt (y_nxt),
    .carry     (frame_wrap_unused)
  );

  // Decoding the next position keeps the registered flags aligned with the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_h_sync    <= 1'b1;
      vga_v_sync    <= 1'b1;
      inDisplayArea <= 1'b1;
    end else begin
      vga_h_sync    <= !((x_nxt >= HSS) && (x_nxt < HSE));
      vga_v_sync    <= !((y_nxt >= VSS) && (y_nxt < VSE));
      inDisplayArea <= (x_nxt < HA) && (y_nxt < VA);
    end
  end
endmodule

// File: tb/tb_hvsync_generator.sv
// Randomised-reset scoreboard bench: a default-timing instance plus a small-timing instance
// whose short frame exercises vertical sync and frame wrap within the cycle budget.
module tb_hvsync_generator;
  localparam int NCYC = 30000;

  // Small timing set: 24 clocks/line, 14 lines/frame.
  localparam int S_HA = 16, S_HSS = 18, S_HSE = 21, S_HT = 24;
  localparam int S_VA = 8,  S_VSS = 10, S_VSE = 12, S_VT = 14;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       hs;
    logic       vs;
    logic       de;
  } obs_t;

  typedef struct packed {
    obs_t d;
    obs_t s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_hs, d_vs, d_de, s_hs, s_vs, s_de;
  logic [9:0] d_x, s_x;
  logic [8:0] d_y, s_y;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   ticks  = 0;
  bit   phase  = 1'b0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  hvsync_generator u_dut_def (
    .clk           (clk),
    .rst           (rst),
    .vga_h_sync    (d_hs),
    .vga_v_sync    (d_vs),
    .inDisplayArea (d_de),
    .CounterX      (d_x),
    .CounterY      (d_y)
  );

  hvsync_generator #(
    .H_ACTIVE(S_HA), .H_SYNC_START(S_HSS), .H_SYNC_END(S_HSE), .H_TOTAL(S_HT),
    .V_ACTIVE(S_VA), .V_SYNC_START(S_VSS), .V_SYNC_END(S_VSE), .V_TOTAL(S_VT)
  ) u_dut_small (
    .clk           (clk),
    .rst           (rst),
    .vga_h_sync    (s_hs),
    .vga_v_sync    (s_vs),
    .inDisplayArea (s_de),
    .CounterX      (s_x),
    .CounterY      (s_y)
  );

  // Position is simply the pixel-tick count since reset folded into line/frame.
  function automatic obs_t model(input int t, input int ha, input int hss, input int hse,
                                 input int ht, input int va, input int vss, input int vse,
                                 input int vt);
    obs_t o;
    int x, y;
    x = t % ht;
    y = (t / ht) % vt;
    o.x  = 10'(x);
    o.y  = 9'(y);
    o.hs = !(x >= hss && x < hse);
    o.vs = !(y >= vss && y < vse);
    o.de = (x < ha) && (y < va);
    return o;
  endfunction

  task automatic issue(input logic r);
    exp_t e;
    rst = r;
    if (r) begin
      ticks = 0;
      phase = 1'b0;
    end else begin
`ifdef HVSYNC_CLKDIV2_EN
      if (phase) ticks++;
      phase = ~phase;
`else
      ticks++;
`endif
    end
    e.d = model(ticks, 640, 720, 736, 768, 480, 500, 502, 512);
    e.s = model(ticks, S_HA, S_HSS, S_HSE, S_HT, S_VA, S_VSS, S_VSE, S_VT);
    exp_q.push_back(e);
  endtask

  task automatic compare(input string name, input obs_t act, input obs_t req);
    checks++;
    if (act === req)
      passed++;
    else
      $display("FAIL %s cyc=%0d actual x=%0d y=%0d hs=%b vs=%b de=%b required x=%0d y=%0d hs=%b vs=%b de=%b",
               name, cyc, act.x, act.y, act.hs, act.vs, act.de,
               req.x, req.y, req.hs, req.vs, req.de);
  endtask

  // Monitor: every edge presents a new position; pop and compare just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL queue_underflow cyc=%0d actual empty required entry", cyc);
      end else begin
        e = exp_q.pop_front();
        compare("default", {d_x, d_y, d_hs, d_vs, d_de}, e.d);
        compare("small",   {s_x, s_y, s_hs, s_vs, s_de}, e.s);
      end
    end
  end

  // Stimulus: 3-cycle reset, long clean run, directed mid-line pulse, then sparse random pulses.
  initial begin
    logic r;
    issue(1'b1);
    for (int i = 1; i < NCYC; i++) begin
      @(negedge clk);
      if (i < 3)
        r = 1'b1;
      else if (i == 9000)
        r = 1'b1;
      else if (i > 9000)
        r = ($urandom_range(0, 3999) == 0);
      else
        r = 1'b0;
      issue(r);
    end
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL queue_drain actual %0d entries required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
